// File: rtl/freq_div_pkg.sv
// rtl/freq_div_pkg.sv - shared FSM state type, default width and high-phase length helper
package freq_div_pkg;

  typedef enum logic {IDLE, RUN} state_t;

  localparam int CNT_W_DEF = 8;

  // Length of the high phase for a period of len cycles; the high phase is the longer half.
  function automatic logic [31:0] high_len(input logic [31:0] len);
    return (len + 32'd1) >> 1;
  endfunction

endpackage

// File: rtl/freq_div_period_cnt.sv
// rtl/freq_div_period_cnt.sv - period counter with registered clk_div and period_start
module freq_div_period_cnt
  import freq_div_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] len,
  input  logic [CNT_W-1:0] len_next,
  input  logic             active,
  input  logic             run,
  output logic [CNT_W-1:0] cnt,
  output logic             last,
  output logic             clk_div,
  output logic             period_start
);

  logic [CNT_W-1:0] cnt_next;
  logic             clk_div_next;
  logic             period_start_next;

  // Outputs are registered from next-cycle values so they line up with cnt.
  always_comb begin
    last              = active && (cnt == len - CNT_W'(1));
    cnt_next          = (active && !last) ? cnt + CNT_W'(1) : '0;
    clk_div_next      = run && (32'(cnt_next) < high_len(32'(len_next)));
    period_start_next = run && (cnt_next == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt          <= '0;
      clk_div      <= 1'b0;
      period_start <= 1'b0;
    end else begin
      cnt          <= cnt_next;
      clk_div      <= clk_div_next;
      period_start <= period_start_next;
    end
  end

endmodule

// File: rtl/freq_div_ctrl.sv
// rtl/freq_div_ctrl.sv - dual-modulus divider controller; FREQ_DIV_CTRL_FRAC_EN enables N+0.5 ratios
module freq_div_ctrl
  import freq_div_pkg::*;
#(
  parameter int CNT_W    = CNT_W_DEF,
  parameter int DEF_DIV  = 3,
  parameter int DEF_HALF = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CNT_W-1:0] cfg_div,
  input  logic             cfg_half,
  output logic             cfg_err,
  output logic             clk_div,
  output logic             period_start,
  output logic             running
);

  state_t           state, state_next;
  logic [CNT_W-1:0] act_div, act_div_next;
  logic [CNT_W-1:0] pend_div;
  logic             pend_v;
  logic [CNT_W-1:0] len, len_next;
  logic [CNT_W-1:0] cnt;
  logic             last;
  logic             xfer, legal, load;

`ifdef FREQ_DIV_CTRL_FRAC_EN
  logic act_half, act_half_next, pend_half, ph, ph_next;
`else
  logic unused_half;
  localparam logic unused_def_half = (DEF_HALF != 0);
  assign unused_half = cfg_half;
`endif

  assign cfg_ready = !pend_v;
  assign running   = (state == RUN);

  always_comb begin
    state_next = state;
    xfer       = cfg_valid && !pend_v;
`ifdef FREQ_DIV_CTRL_FRAC_EN
    legal      = (cfg_div >= CNT_W'(2)) && (cfg_div != '1);
`else
    legal      = (cfg_div >= CNT_W'(2));
`endif
    // Shadow is promoted immediately in IDLE, otherwise only at a period boundary.
    load         = pend_v && ((state == IDLE) || last);
    act_div_next = load ? pend_div : act_div;
    case (state)
      IDLE:    if (enable) state_next = RUN;
      RUN:     if (last && !enable) state_next = IDLE;
      default: state_next = IDLE;
    endcase
`ifdef FREQ_DIV_CTRL_FRAC_EN
    act_half_next = load ? pend_half : act_half;
    if (state == IDLE)  ph_next = 1'b0;
    else if (last)      ph_next = pend_v ? 1'b0 : !ph;
    else                ph_next = ph;
    len      = (act_half && !ph) ? act_div + CNT_W'(1) : act_div;
    len_next = (act_half_next && !ph_next) ? act_div_next + CNT_W'(1) : act_div_next;
`else
    len      = act_div;
    len_next = act_div_next;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      act_div  <= CNT_W'(DEF_DIV);
      pend_div <= '0;
      pend_v   <= 1'b0;
      cfg_err  <= 1'b0;
`ifdef FREQ_DIV_CTRL_FRAC_EN
      act_half  <= (DEF_HALF != 0);
      pend_half <= 1'b0;
      ph        <= 1'b0;
`endif
    end else begin
      state   <= state_next;
      act_div <= act_div_next;
      cfg_err <= xfer && !legal;
      if (xfer && legal) begin
        pend_v   <= 1'b1;
        pend_div <= cfg_div;
      end else if (load) begin
        pend_v <= 1'b0;
      end
`ifdef FREQ_DIV_CTRL_FRAC_EN
      act_half <= act_half_next;
      ph       <= ph_next;
      if (xfer && legal) pend_half <= cfg_half;
`endif
    end
  end

  freq_div_period_cnt #(.CNT_W(CNT_W)) u_period_cnt (
    .clk          (clk),
    .rst          (rst),
    .len          (len),
    .len_next     (len_next),
    .active       (state == RUN),
    .run          (state_next == RUN),
    .cnt          (cnt),
    .last         (last),
    .clk_div      (clk_div),
    .period_start (period_start)
  );

endmodule

// File: tb/tb_freq_div_ctrl.sv
// tb/tb_freq_div_ctrl.sv - scoreboard bench for freq_div_ctrl
module tb_freq_div_ctrl;

`ifdef FREQ_DIV_CTRL_FRAC_EN
  localparam int D0 = 4;
  localparam int D1 = 3;
`else
  localparam int D0 = 3;
  localparam int D1 = 3;
`endif

  logic       clk = 1'b0;
  logic       rst, enable, cfg_valid, cfg_half;
  logic [7:0] cfg_div;
  logic       cfg_ready, cfg_err, clk_div, period_start, running;
  int         checks = 0;
  int         errors = 0;
  // {clk_div, period_start, cfg_ready, cfg_err, running}
  logic [4:0] sb[$];

  always #5 clk = ~clk;

  freq_div_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_div      (cfg_div),
    .cfg_half     (cfg_half),
    .cfg_err      (cfg_err),
    .clk_div      (clk_div),
    .period_start (period_start),
    .running      (running)
  );

  task automatic push_period(input int len, input int busy_from, input int err_at);
    for (int c = 0; c < len; c++)
      sb.push_back({c < (len + 1) / 2, c == 0, c < busy_from, c == err_at, 1'b1});
  endtask

  task automatic push_idle(input int n, input int busy_at);
    for (int c = 0; c < n; c++)
      sb.push_back({1'b0, 1'b0, c != busy_at, 1'b0, 1'b0});
  endtask

  task automatic test_reset();
    logic [4:0] exp, obs;
    push_idle(3, -1);
    for (int i = 0; sb.size() > 0; i++) begin
      rst = (i < 2);
      @(posedge clk); #1;
      exp = sb.pop_front();
      obs = {clk_div, period_start, cfg_ready, cfg_err, running};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL reset cycle %0d: got %b expected %b", i, obs, exp);
      end
    end
  endtask

  task automatic test_default_ratio();
    logic [4:0] exp, obs;
    push_period(D0, D0, -1); push_period(D1, D1, -1);
    push_period(D0, D0, -1); push_period(D1, D1, -1);
    for (int i = 0; sb.size() > 0; i++) begin
      if (i == 0) enable = 1'b1;
      @(posedge clk); #1;
      exp = sb.pop_front();
      obs = {clk_div, period_start, cfg_ready, cfg_err, running};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL default_ratio cycle %0d: got %b expected %b", i, obs, exp);
      end
    end
  endtask

  task automatic test_cfg_midperiod();
    logic [4:0] exp, obs;
    push_period(D0, 1, -1);
    for (int p = 0; p < 3; p++) push_period(4, 4, -1);
    for (int i = 0; sb.size() > 0; i++) begin
      if (i == 1) begin cfg_valid = 1'b1; cfg_div = 8'd4; cfg_half = 1'b0; end
      if (i == 2) cfg_valid = 1'b0;
      @(posedge clk); #1;
      exp = sb.pop_front();
      obs = {clk_div, period_start, cfg_ready, cfg_err, running};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL cfg_midperiod cycle %0d: got %b expected %b", i, obs, exp);
      end
    end
  endtask

  task automatic test_cfg_error();
    logic [4:0] exp, obs;
    push_period(4, 4, 1); push_period(4, 4, 1);
    for (int i = 0; sb.size() > 0; i++) begin
      if (i == 1) begin cfg_valid = 1'b1; cfg_div = 8'd1; end
      if (i == 5) begin cfg_valid = 1'b1; cfg_div = 8'd0; end
      if (i == 2 || i == 6) cfg_valid = 1'b0;
      @(posedge clk); #1;
      exp = sb.pop_front();
      obs = {clk_div, period_start, cfg_ready, cfg_err, running};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL cfg_error cycle %0d: got %b expected %b", i, obs, exp);
      end
    end
  endtask

  task automatic test_graceful_disable();
    logic [4:0] exp, obs;
    push_period(4, 1, -1); push_period(5, 5, -1); push_idle(2, -1);
    for (int i = 0; sb.size() > 0; i++) begin
      if (i == 1) begin cfg_valid = 1'b1; cfg_div = 8'd5; cfg_half = 1'b0; end
      if (i == 2) cfg_valid = 1'b0;
      if (i == 5) enable = 1'b0;
      @(posedge clk); #1;
      exp = sb.pop_front();
      obs = {clk_div, period_start, cfg_ready, cfg_err, running};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL graceful_disable cycle %0d: got %b expected %b", i, obs, exp);
      end
    end
  endtask

  task automatic test_boundary_transfer();
    logic [4:0] exp, obs;
    push_idle(2, 0);
    push_period(6, 6, -1); push_period(6, 0, -1);
    push_period(3, 3, -1); push_period(3, 3, -1);
    for (int i = 0; sb.size() > 0; i++) begin
      if (i == 0) begin cfg_valid = 1'b1; cfg_div = 8'd6; cfg_half = 1'b0; end
      if (i == 1 || i == 9) cfg_valid = 1'b0;
      if (i == 2) enable = 1'b1;
      if (i == 8) begin cfg_valid = 1'b1; cfg_div = 8'd3; cfg_half = 1'b0; end
      @(posedge clk); #1;
      exp = sb.pop_front();
      obs = {clk_div, period_start, cfg_ready, cfg_err, running};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL boundary_transfer cycle %0d: got %b expected %b", i, obs, exp);
      end
    end
  endtask

  task automatic test_reset_midrun();
    logic [4:0] exp, obs;
    push_period(3, 1, -1); push_idle(1, -1);
    push_period(D0, D0, -1); push_period(D1, D1, -1);
    for (int i = 0; sb.size() > 0; i++) begin
      if (i == 1) begin cfg_valid = 1'b1; cfg_div = 8'd7; cfg_half = 1'b0; end
      if (i == 2) cfg_valid = 1'b0;
      if (i == 3) rst = 1'b1;
      if (i == 4) begin rst = 1'b0; enable = 1'b1; end
      @(posedge clk); #1;
      exp = sb.pop_front();
      obs = {clk_div, period_start, cfg_ready, cfg_err, running};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL reset_midrun cycle %0d: got %b expected %b", i, obs, exp);
      end
    end
  endtask

  initial begin
    rst       = 1'b1;
    enable    = 1'b0;
    cfg_valid = 1'b0;
    cfg_div   = 8'd0;
    cfg_half  = 1'b0;
    test_reset();
    test_default_ratio();
    test_cfg_midperiod();
    test_cfg_error();
    test_graceful_disable();
    test_boundary_transfer();
    test_reset_midrun();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
